// File: rtl/reg_select_debouncer.sv
// ----------------------------------------------------------------------------
// reg_select_debouncer
//
// Front-end for the register-select path. Four raw push-buttons are
// synchronised (2 flops per bit) and debounced by per-button counters. Each
// debounced rising edge (press) loads a one-hot register-select word. When
// several presses arrive together, the lowest index wins. SEL is never
// all-zero, so the downstream 4-to-2 priority converter is always defined.
//
// Optional feature: define REG_SEL_LOCK_EN to add the LOCK input. While LOCK=1,
// presses are discarded. Debounce and press history keep running.
//
// Parameters
//   CNT_W            width of each per-button debounce counter
//   DEBOUNCE_CYCLES  consecutive stable cycles before a level is accepted
//                    (1 .. 2^CNT_W-1)
// Ports
//   CLK     in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   BTN     in   [3:0] raw button levels (async to CLK), 1 = pressed
//   LOCK    in   (REG_SEL_LOCK_EN only) 1 = ignore presses
//   SEL     out  [3:0] one-hot register select, held until next accepted press
//   NEW     out  one-cycle pulse on the edge where SEL is (re)loaded
//   STABLE  out  [3:0] debounced button levels
// ----------------------------------------------------------------------------
module reg_select_debouncer #(
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] BTN,
`ifdef REG_SEL_LOCK_EN
    input  logic       LOCK,
`endif
    output logic [3:0] SEL,
    output logic       NEW,
    output logic [3:0] STABLE
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       hist_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       sel_q, sel_d;
    logic             new_q, new_d;
    logic [3:0]       press;

    // Debounce: count consecutive cycles where the synchronised level differs
    // from the accepted level; any return to the accepted level clears it.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press is a debounced rising edge, optionally masked by LOCK.
    always_comb begin
        press = stable_q & ~hist_q;
`ifdef REG_SEL_LOCK_EN
        if (LOCK) begin
            press = 4'b0000;
        end
`endif
    end

    // Select latch: scanning downward leaves the lowest set press bit last.
    always_comb begin
        sel_d = sel_q;
        new_d = 1'b0;
        if (press != 4'b0000) begin
            new_d = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                if (press[i]) begin
                    sel_d    = 4'b0000;
                    sel_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            stable_q <= 4'b0000;
            hist_q   <= 4'b0000;
            sel_q    <= 4'b0001;
            new_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= BTN;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            hist_q   <= stable_q;
            sel_q    <= sel_d;
            new_q    <= new_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign SEL    = sel_q;
    assign NEW    = new_q;
    assign STABLE = stable_q;

endmodule

// File: tb/tb_reg_select_debouncer.sv
// ----------------------------------------------------------------------------
// tb_reg_select_debouncer
//
// Self-checking bench for reg_select_debouncer with DEBOUNCE_CYCLES=4, CNT_W=3.
// Directed scenarios plus a randomised phase, all compared every cycle against
// a behavioural model. The model accepts a level when the last DEBOUNCE_CYCLES
// synchronised samples all differ from the accepted level, and it selects the
// lowest pressed button arithmetically. Compile with +define+REG_SEL_LOCK_EN
// to also exercise LOCK.
// ----------------------------------------------------------------------------
module tb_reg_select_debouncer;

    localparam int unsigned CntW = 3;
    localparam int unsigned Deb  = 4;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] BTN   = 4'b0000;
    logic       LOCK  = 1'b0;
    logic [3:0] SEL;
    logic       NEW;
    logic [3:0] STABLE;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    reg_select_debouncer #(
        .CNT_W          (CntW),
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .BTN   (BTN),
`ifdef REG_SEL_LOCK_EN
        .LOCK  (LOCK),
`endif
        .SEL   (SEL),
        .NEW   (NEW),
        .STABLE(STABLE)
    );

    // ---------------- behavioural model ----------------
    logic [3:0] m_sel, m_stable, m_hist;
    logic       m_new;
    logic [3:0] m_samp[$];  // BTN as sampled at each edge since reset

    task automatic model_reset();
        m_sel    = 4'b0001;
        m_stable = 4'b0000;
        m_hist   = 4'b0000;
        m_new    = 1'b0;
        m_samp.delete();
    endtask

    // BTN seen at post-reset edge j (1-based); zero before reset release.
    function automatic logic [3:0] samp_at(int j);
        return (j >= 1) ? m_samp[j-1] : 4'b0000;
    endfunction

    task automatic model_edge(input logic [3:0] b, input logic lk);
        logic [3:0] press, flip;
        int k;
        press = lk ? 4'b0000 : (m_stable & ~m_hist);
        m_new = (press != 4'b0000);
        if (press != 4'b0000) m_sel = press & (~press + 4'd1);
        m_hist = m_stable;
        // The synchronised level before edge m is the BTN sampled at edge m-2.
        k    = m_samp.size() + 1;
        flip = 4'b0000;
        if (k >= int'(Deb)) begin
            flip = 4'b1111;
            for (int m = k - int'(Deb) + 1; m <= k; m++) begin
                flip &= samp_at(m - 2) ^ m_stable;
            end
        end
        m_stable ^= flip;
        m_samp.push_back(b);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model, then compare on the falling edge.
    task automatic step(input string tag);
        @(posedge CLK);
        if (RST_N) model_edge(BTN, LOCK);
        @(negedge CLK);
        check({tag, "/sel"}, {28'b0, SEL}, {28'b0, m_sel});
        check({tag, "/new"}, {31'b0, NEW}, {31'b0, m_new});
        check({tag, "/stable"}, {28'b0, STABLE}, {28'b0, m_stable});
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic do_reset(input int cycles);
        RST_N = 1'b0;
        model_reset();
        #1;
        check("rst/sel", {28'b0, SEL}, 32'h1);
        check("rst/new", {31'b0, NEW}, 32'h0);
        check("rst/stable", {28'b0, STABLE}, 32'h0);
        steps("in_rst", cycles);
        RST_N = 1'b1;
    endtask

    int pulses;

    initial begin
        model_reset();
        @(negedge CLK);

        // 1. Reset and idle
        do_reset(2);
        steps("idle", 5);
        check("t1_sel", {28'b0, SEL}, 32'h1);
        check("t1_new", {31'b0, NEW}, 32'h0);
        check("t1_stable", {28'b0, STABLE}, 32'h0);

        // 2. BTN[2] held: STABLE at edge 6, SEL/NEW at edge 7 only
        BTN = 4'b0100;
        steps("t2", 5);
        check("t2_stable_e5", {28'b0, STABLE}, 32'h0);
        step("t2");
        check("t2_stable_e6", {28'b0, STABLE}, 32'h4);
        check("t2_new_e6", {31'b0, NEW}, 32'h0);
        step("t2");
        check("t2_sel_e7", {28'b0, SEL}, 32'h4);
        check("t2_new_e7", {31'b0, NEW}, 32'h1);
        step("t2");
        check("t2_new_e8", {31'b0, NEW}, 32'h0);
        BTN = 4'b0000;
        steps("t2_rel", 10);

        // 3. Short glitch on BTN[1] never accepted
        BTN = 4'b0010;
        steps("t3", 3);
        BTN = 4'b0000;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step("t3");
            if (NEW) pulses++;
        end
        check("t3_sel", {28'b0, SEL}, 32'h4);
        check("t3_stable", {28'b0, STABLE}, 32'h0);
        check("t3_pulses", pulses, 32'h0);

        // 4. Simultaneous press: lowest wins, single pulse, release keeps SEL
        BTN = 4'b1010;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step("t4");
            if (NEW) pulses++;
        end
        check("t4_sel", {28'b0, SEL}, 32'h2);
        check("t4_pulses", pulses, 32'h1);
        BTN = 4'b0000;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step("t4_rel");
            if (NEW) pulses++;
        end
        check("t4_sel_rel", {28'b0, SEL}, 32'h2);
        check("t4_pulses_rel", pulses, 32'h0);

        // 5. Reset mid-count with BTN[3] held through reset release
        BTN = 4'b1000;
        steps("t5_pre", 3);
        do_reset(2);
        steps("t5", 6);
        check("t5_sel_e6", {28'b0, SEL}, 32'h1);
        step("t5");
        check("t5_sel_e7", {28'b0, SEL}, 32'h8);
        check("t5_new_e7", {31'b0, NEW}, 32'h1);
        BTN = 4'b0000;
        steps("t5_rel", 10);

`ifdef REG_SEL_LOCK_EN
        // 6. Press under LOCK, drop LOCK while held: no press; fresh press works
        LOCK = 1'b1;
        BTN  = 4'b0100;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step("t6_lock");
            if (NEW) pulses++;
        end
        LOCK = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step("t6_held");
            if (NEW) pulses++;
        end
        check("t6_sel_locked", {28'b0, SEL}, 32'h8);
        check("t6_pulses", pulses, 32'h0);
        BTN = 4'b0000;
        steps("t6_rel", 10);
        BTN = 4'b0100;
        steps("t6_fresh", 8);
        check("t6_sel_fresh", {28'b0, SEL}, 32'h4);
        BTN = 4'b0000;
        steps("t6_rel2", 10);
`endif

        // Randomised phase: random levels with random hold lengths
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) == 0) BTN = 4'b0000;
            else BTN = 4'($urandom_range(0, 15));
`ifdef REG_SEL_LOCK_EN
            LOCK = ($urandom_range(0, 4) == 0);
`endif
            steps("rand", $urandom_range(1, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
